pf_vf_route_lookup: RTL

- Pipelined, runtime-programmable PF/VF routing table for the PF/VF MUX; replaces the elaboration-time constant routing table.
- Each request carries {pf, vf, vf_active, tag}. The block returns the MUX port of the lowest-indexed valid matching entry, or DEFAULT_PORT with a miss flag.
- Software or the FME programs entries through a write port. The block sits between the TLP header decode and the MUX port-select logic.

---
 rtl/pf_vf_route_lookup_pkg.sv | 30 +++
 rtl/pf_vf_route_prio_enc.sv | 22 ++
 rtl/pf_vf_route_lookup.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pf_vf_route_lookup_pkg.sv
// Shared types for the PF/VF routing table: entry layout and the per-entry match rule.
package pf_vf_route_pkg;

    localparam int PF_W = 3;
    localparam int VF_W = 11;

    typedef struct packed {
        logic            valid;
        logic            vf_active;
        logic            pf_any;
        logic            vf_any;
        logic [PF_W-1:0] pf;
        logic [VF_W-1:0] vf;
        logic [7:0]      port;
    } t_route_entry;

    // vf_active has no wildcard: PF-only traffic never hits a VF entry and vice versa.
    function automatic logic route_entry_matches(
        input t_route_entry    entry,
        input logic [PF_W-1:0] pf,
        input logic [VF_W-1:0] vf,
        input logic            vf_active
    );
        return entry.valid
            && (entry.vf_active == vf_active)
            && (entry.pf_any || (entry.pf == pf))
            && (entry.vf_any || (entry.vf == vf));
    endfunction

endpackage

// File: rtl/pf_vf_route_prio_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set and the index of the lowest one.
module pf_vf_route_prio_enc #(
    parameter int  NUM_ENTRIES = 16,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic [NUM_ENTRIES-1:0] i_vec,
    output logic                   o_hit,
    output logic [IDX_W-1:0]       o_idx
);

    always_comb begin
        o_hit = |i_vec;
        o_idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pf_vf_route_lookup.sv
// Runtime-programmable PF/VF -> MUX port routing table, two-stage stall-all lookup pipeline.
module pf_vf_route_lookup
    import pf_vf_route_pkg::*;
#(
    parameter int  NUM_ENTRIES  = 16,
    parameter int  NUM_PORTS    = 8,
    parameter int  TAG_WIDTH    = 8,
    parameter int  DEFAULT_PORT = 0,
    localparam int PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int ENTRY_W      = $bits(t_route_entry)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PF_W-1:0]      req_pf,
    input  logic [VF_W-1:0]      req_vf,
    input  logic                 req_vf_active,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PORT_W-1:0]    rsp_port,
    output logic                 rsp_miss,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    input  logic                 tbl_wr_en,
    input  logic [IDX_W-1:0]     tbl_wr_idx,
    input  logic [ENTRY_W-1:0]   tbl_wr_entry,
    output logic [31:0]          miss_count
);

    t_route_entry                       r_tbl [NUM_ENTRIES];
    logic                               r_vld_p1;
    logic [NUM_ENTRIES-1:0]             r_match_p1;
    logic [NUM_ENTRIES-1:0][PORT_W-1:0] r_ports_p1;
    logic [TAG_WIDTH-1:0]               r_tag_p1;
    logic                               r_vld_p2;
    logic [PORT_W-1:0]                  r_port_p2;
    logic                               r_miss_p2;
    logic [TAG_WIDTH-1:0]               r_tag_p2;
    logic [31:0]                        r_miss_count;

    logic                               w_stall;
    logic                               w_accept;
    t_route_entry                       w_wr_entry;
    t_route_entry                       w_wr_store;
    logic                               w_wr_idx_ok;
    logic                               w_wr_port_ok;
    logic [NUM_ENTRIES-1:0]             w_match;
    logic [NUM_ENTRIES-1:0][PORT_W-1:0] w_ports;
    logic                               w_hit;
    logic [IDX_W-1:0]                   w_idx;

    assign w_stall   = r_vld_p2 && !rsp_ready;
    assign req_ready = !w_stall;
    assign w_accept  = req_valid && req_ready;

    assign w_wr_entry   = t_route_entry'(tbl_wr_entry);
    assign w_wr_idx_ok  = 32'(tbl_wr_idx) < 32'(NUM_ENTRIES);
    assign w_wr_port_ok = 32'(w_wr_entry.port) < 32'(NUM_PORTS);

    // An out-of-range port is kept but can never be selected.
    always_comb begin
        w_wr_store       = w_wr_entry;
        w_wr_store.valid = w_wr_entry.valid && w_wr_port_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (tbl_wr_en && w_wr_idx_ok) begin
            r_tbl[tbl_wr_idx] <= w_wr_store;
        end
    end

    // Ports are snapshotted with the match vector so a write landing while the
    // request sits in S1 cannot change its routing decision.
    always_comb begin
        w_match = '0;
        w_ports = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = route_entry_matches(r_tbl[i], req_pf, req_vf, req_vf_active);
            w_ports[i] = PORT_W'(r_tbl[i].port);
        end
    end

    // ---- S1: match vector, port snapshot, tag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (!w_stall) begin
            r_vld_p1 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall && w_accept) begin
            r_match_p1 <= w_match;
            r_ports_p1 <= w_ports;
            r_tag_p1   <= req_tag;
        end
    end

    pf_vf_route_prio_enc #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_prio_enc (
        .i_vec(r_match_p1),
        .o_hit(w_hit),
        .o_idx(w_idx)
    );

    // ---- S2: priority-encoded routing decision drives rsp_* ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
        end else if (!w_stall) begin
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port_p2 <= PORT_W'(DEFAULT_PORT);
            r_miss_p2 <= 1'b0;
            r_tag_p2  <= '0;
        end else if (!w_stall && r_vld_p1) begin
            r_port_p2 <= w_hit ? r_ports_p1[w_idx] : PORT_W'(DEFAULT_PORT);
            r_miss_p2 <= !w_hit;
            r_tag_p2  <= r_tag_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_count <= '0;
        end else if (r_vld_p2 && rsp_ready && r_miss_p2 && (r_miss_count != 32'hFFFF_FFFF)) begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign rsp_valid  = r_vld_p2;
    assign rsp_port   = r_port_p2;
    assign rsp_miss   = r_miss_p2;
    assign rsp_tag    = r_tag_p2;
    assign miss_count = r_miss_count;

endmodule
